// File: rtl/rice_core_id_stage.sv
// RV32I instruction decode stage.
// Takes the fetch FIFO head, reads both source operands with writeback
// bypass, decodes class/fields/immediate, detects load-use hazards and
// registers the result into the ID/EX pipeline register.
module rice_core_id_stage #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_enable,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_if_valid,
    input  logic [XLEN-1:0] i_if_pc,
    input  logic [31:0]     i_if_inst,
    output logic            o_if_stall,
    output logic [4:0]      o_rs1_addr,
    output logic [4:0]      o_rs2_addr,
    input  logic [XLEN-1:0] i_rs1_value,
    input  logic [XLEN-1:0] i_rs2_value,
    input  logic            i_wb_valid,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_value,
    input  logic            i_ex_valid,
    input  logic            i_ex_is_load,
    input  logic [4:0]      i_ex_rd,
    output logic            o_id_valid,
    output logic [XLEN-1:0] o_id_pc,
    output logic [3:0]      o_id_class,
    output logic [2:0]      o_id_funct3,
    output logic            o_id_funct7b5,
    output logic [4:0]      o_id_rd,
    output logic [XLEN-1:0] o_id_rs1_value,
    output logic [XLEN-1:0] o_id_rs2_value,
    output logic [XLEN-1:0] o_id_imm
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] CLS_LUI     = 4'd0;
    localparam logic [3:0] CLS_AUIPC   = 4'd1;
    localparam logic [3:0] CLS_JAL     = 4'd2;
    localparam logic [3:0] CLS_JALR    = 4'd3;
    localparam logic [3:0] CLS_BRANCH  = 4'd4;
    localparam logic [3:0] CLS_LOAD    = 4'd5;
    localparam logic [3:0] CLS_STORE   = 4'd6;
    localparam logic [3:0] CLS_OP_IMM  = 4'd7;
    localparam logic [3:0] CLS_OP      = 4'd8;
    localparam logic [3:0] CLS_FENCE   = 4'd9;
    localparam logic [3:0] CLS_SYSTEM  = 4'd10;
    localparam logic [3:0] CLS_ILLEGAL = 4'd15;

    // Register-file read with writeback bypass; x0 always reads zero.
    function automatic logic [XLEN-1:0] read_operand(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] rf_value,
        input logic            wb_valid,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_value
    );
        if (addr == 5'd0)
            return '0;
        else if (wb_valid && (wb_rd == addr))
            return wb_value;
        else
            return rf_value;
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_addr;
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;

    assign opcode   = i_if_inst[6:0];
    assign rd_addr  = i_if_inst[11:7];
    assign funct3   = i_if_inst[14:12];
    assign rs1_addr = i_if_inst[19:15];
    assign rs2_addr = i_if_inst[24:20];
    assign funct7   = i_if_inst[31:25];

    assign o_rs1_addr = rs1_addr;
    assign o_rs2_addr = rs2_addr;

    logic signed [XLEN-1:0] imm_i;
    logic signed [XLEN-1:0] imm_s;
    logic signed [XLEN-1:0] imm_b;
    logic signed [XLEN-1:0] imm_u;
    logic signed [XLEN-1:0] imm_j;

    assign imm_i = {{20{i_if_inst[31]}}, i_if_inst[31:20]};
    assign imm_s = {{20{i_if_inst[31]}}, i_if_inst[31:25], i_if_inst[11:7]};
    assign imm_b = {{19{i_if_inst[31]}}, i_if_inst[31], i_if_inst[7],
                    i_if_inst[30:25], i_if_inst[11:8], 1'b0};
    assign imm_u = {i_if_inst[31:12], 12'b0};
    assign imm_j = {{11{i_if_inst[31]}}, i_if_inst[31], i_if_inst[19:12],
                    i_if_inst[20], i_if_inst[30:21], 1'b0};

    logic [3:0]             dec_cls;
    logic signed [XLEN-1:0] dec_imm;
    logic [4:0]             dec_rd;
    logic                   uses_rs1;
    logic                   uses_rs2;
    logic                   hazard;
    logic [XLEN-1:0]        rs1_value;
    logic [XLEN-1:0]        rs2_value;

    // Classify the opcode, rejecting reserved funct3/funct7 encodings.
    always_comb begin
        dec_cls = CLS_ILLEGAL;
        if (i_if_inst[1:0] == 2'b11) begin
            case (opcode)
                OPC_LUI:    dec_cls = CLS_LUI;
                OPC_AUIPC:  dec_cls = CLS_AUIPC;
                OPC_JAL:    dec_cls = CLS_JAL;
                OPC_JALR:   if (funct3 == 3'b000) dec_cls = CLS_JALR;
                OPC_BRANCH: if (funct3 != 3'b010 && funct3 != 3'b011) dec_cls = CLS_BRANCH;
                OPC_LOAD:   if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111)
                                dec_cls = CLS_LOAD;
                OPC_STORE:  if (funct3 < 3'b011) dec_cls = CLS_STORE;
                OPC_OP_IMM: if (!((funct3 == 3'b001 && funct7 != 7'h00) ||
                                  (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)))
                                dec_cls = CLS_OP_IMM;
                OPC_OP:     if (funct7 == 7'h00 ||
                                (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))
                                dec_cls = CLS_OP;
                OPC_FENCE:  dec_cls = CLS_FENCE;
                OPC_SYSTEM: dec_cls = CLS_SYSTEM;
                default:    dec_cls = CLS_ILLEGAL;
            endcase
        end
    end

    // Per-class immediate format, source usage and destination masking.
    always_comb begin
        dec_imm  = '0;
        dec_rd   = rd_addr;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (dec_cls)
            CLS_LUI, CLS_AUIPC: dec_imm = imm_u;
            CLS_JAL:            dec_imm = imm_j;
            CLS_JALR, CLS_LOAD, CLS_OP_IMM: begin
                dec_imm  = imm_i;
                uses_rs1 = 1'b1;
            end
            CLS_SYSTEM:         dec_imm = imm_i;
            CLS_BRANCH: begin
                dec_imm  = imm_b;
                dec_rd   = 5'd0;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            CLS_STORE: begin
                dec_imm  = imm_s;
                dec_rd   = 5'd0;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            CLS_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            default:            dec_rd = 5'd0;
        endcase
    end

    assign rs1_value = read_operand(rs1_addr, i_rs1_value, i_wb_valid, i_wb_rd, i_wb_value);
    assign rs2_value = read_operand(rs2_addr, i_rs2_value, i_wb_valid, i_wb_rd, i_wb_value);

    // A load in EX cannot forward in time; hold the consumer in the fetch FIFO.
    assign hazard = i_if_valid && i_ex_valid && i_ex_is_load && (i_ex_rd != 5'd0) &&
                    ((uses_rs1 && (rs1_addr == i_ex_rd)) || (uses_rs2 && (rs2_addr == i_ex_rd)));

    assign o_if_stall = i_stall || hazard;

    logic            vld_p1;
    logic [XLEN-1:0] pc_p1;
    logic [3:0]      cls_p1;
    logic [2:0]      funct3_p1;
    logic            funct7b5_p1;
    logic [4:0]      rd_p1;
    logic [XLEN-1:0] rs1_value_p1;
    logic [XLEN-1:0] rs2_value_p1;
    logic [XLEN-1:0] imm_p1;

    // ID/EX register: reset/disable clear, then flush > stall > hazard > load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n || !i_enable) begin
            vld_p1       <= 1'b0;
            pc_p1        <= '0;
            cls_p1       <= '0;
            funct3_p1    <= '0;
            funct7b5_p1  <= 1'b0;
            rd_p1        <= '0;
            rs1_value_p1 <= '0;
            rs2_value_p1 <= '0;
            imm_p1       <= '0;
        end else if (i_flush) begin
            vld_p1 <= 1'b0;
        end else if (!i_stall) begin
            if (hazard) begin
                vld_p1 <= 1'b0;
            end else begin
                vld_p1 <= i_if_valid;
                if (i_if_valid) begin
                    pc_p1        <= i_if_pc;
                    cls_p1       <= dec_cls;
                    funct3_p1    <= funct3;
                    funct7b5_p1  <= i_if_inst[30];
                    rd_p1        <= dec_rd;
                    rs1_value_p1 <= rs1_value;
                    rs2_value_p1 <= rs2_value;
                    imm_p1       <= dec_imm;
                end
            end
        end
    end

    assign o_id_valid     = vld_p1;
    assign o_id_pc        = pc_p1;
    assign o_id_class     = cls_p1;
    assign o_id_funct3    = funct3_p1;
    assign o_id_funct7b5  = funct7b5_p1;
    assign o_id_rd        = rd_p1;
    assign o_id_rs1_value = rs1_value_p1;
    assign o_id_rs2_value = rs2_value_p1;
    assign o_id_imm       = imm_p1;

endmodule

// File: tb/tb_rice_core_id_stage.sv
// Directed testbench for rice_core_id_stage with an expectation queue.
module tb_rice_core_id_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_enable;
    logic        i_stall;
    logic        i_flush;
    logic        i_if_valid;
    logic [31:0] i_if_pc;
    logic [31:0] i_if_inst;
    logic        o_if_stall;
    logic [4:0]  o_rs1_addr;
    logic [4:0]  o_rs2_addr;
    logic [31:0] i_rs1_value;
    logic [31:0] i_rs2_value;
    logic        i_wb_valid;
    logic [4:0]  i_wb_rd;
    logic [31:0] i_wb_value;
    logic        i_ex_valid;
    logic        i_ex_is_load;
    logic [4:0]  i_ex_rd;
    logic        o_id_valid;
    logic [31:0] o_id_pc;
    logic [3:0]  o_id_class;
    logic [2:0]  o_id_funct3;
    logic        o_id_funct7b5;
    logic [4:0]  o_id_rd;
    logic [31:0] o_id_rs1_value;
    logic [31:0] o_id_rs2_value;
    logic [31:0] o_id_imm;

    rice_core_id_stage #(.XLEN(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
        .i_stall(i_stall), .i_flush(i_flush),
        .i_if_valid(i_if_valid), .i_if_pc(i_if_pc), .i_if_inst(i_if_inst),
        .o_if_stall(o_if_stall), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
        .i_rs1_value(i_rs1_value), .i_rs2_value(i_rs2_value),
        .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .i_wb_value(i_wb_value),
        .i_ex_valid(i_ex_valid), .i_ex_is_load(i_ex_is_load), .i_ex_rd(i_ex_rd),
        .o_id_valid(o_id_valid), .o_id_pc(o_id_pc), .o_id_class(o_id_class),
        .o_id_funct3(o_id_funct3), .o_id_funct7b5(o_id_funct7b5), .o_id_rd(o_id_rd),
        .o_id_rs1_value(o_id_rs1_value), .o_id_rs2_value(o_id_rs2_value),
        .o_id_imm(o_id_imm)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  cls;
        logic [2:0]  f3;
        logic        f7b5;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] inst,
                           input logic [31:0] r1, input logic [31:0] r2);
        i_if_valid  = 1'b1;
        i_if_pc     = pc;
        i_if_inst   = inst;
        i_rs1_value = r1;
        i_rs2_value = r2;
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [3:0] cls, input logic [2:0] f3,
                        input logic f7b5, input logic [4:0] rd, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm);
        exp_t e;
        e.pc = pc; e.cls = cls; e.f3 = f3; e.f7b5 = f7b5;
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
        sb.push_back(e);
    endtask

    task automatic cmp_fields(input string tag, input exp_t e);
        chk({tag, ".valid"}, 32'(o_id_valid), 32'd1);
        chk({tag, ".pc"}, o_id_pc, e.pc);
        chk({tag, ".class"}, 32'(o_id_class), 32'(e.cls));
        chk({tag, ".funct3"}, 32'(o_id_funct3), 32'(e.f3));
        chk({tag, ".funct7b5"}, 32'(o_id_funct7b5), 32'(e.f7b5));
        chk({tag, ".rd"}, 32'(o_id_rd), 32'(e.rd));
        chk({tag, ".rs1"}, o_id_rs1_value, e.rs1);
        chk({tag, ".rs2"}, o_id_rs2_value, e.rs2);
        chk({tag, ".imm"}, o_id_imm, e.imm);
    endtask

    task automatic expect_out(input string tag);
        chk({tag, ".sb_pending"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            last_exp = sb.pop_front();
            cmp_fields(tag, last_exp);
        end
    endtask

    task automatic expect_zero(input string tag);
        chk({tag, ".valid"}, 32'(o_id_valid), 32'd0);
        chk({tag, ".pc"}, o_id_pc, 32'd0);
        chk({tag, ".class"}, 32'(o_id_class), 32'd0);
        chk({tag, ".funct3"}, 32'(o_id_funct3), 32'd0);
        chk({tag, ".funct7b5"}, 32'(o_id_funct7b5), 32'd0);
        chk({tag, ".rd"}, 32'(o_id_rd), 32'd0);
        chk({tag, ".rs1"}, o_id_rs1_value, 32'd0);
        chk({tag, ".rs2"}, o_id_rs2_value, 32'd0);
        chk({tag, ".imm"}, o_id_imm, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0; i_enable = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
        i_if_valid = 1'b0; i_if_pc = '0; i_if_inst = '0;
        i_rs1_value = '0; i_rs2_value = '0;
        i_wb_valid = 1'b0; i_wb_rd = '0; i_wb_value = '0;
        i_ex_valid = 1'b0; i_ex_is_load = 1'b0; i_ex_rd = '0;
        tick(); tick();
        expect_zero("reset");
        chk("reset.if_stall", 32'(o_if_stall), 32'd0);
        i_rst_n = 1'b1;
        tick();

        // ADDI x1,x0,5
        present(32'h8000_0000, 32'h0050_0093, 32'hDEAD_BEEF, 32'h0000_0BAD);
        chk("addi.if_stall", 32'(o_if_stall), 32'd0);
        chk("addi.rs1_addr", 32'(o_rs1_addr), 32'd0);
        chk("addi.rs2_addr", 32'(o_rs2_addr), 32'd5);
        push(32'h8000_0000, 4'd7, 3'd0, 1'b0, 5'd1, 32'h0, 32'h0000_0BAD, 32'd5);
        tick();
        expect_out("addi");

        // ADD x3,x2,x1 behind a load writing x2
        i_ex_valid = 1'b1; i_ex_is_load = 1'b1; i_ex_rd = 5'd2;
        present(32'h8000_0004, 32'h0011_01B3, 32'h22, 32'h11);
        chk("loaduse.if_stall", 32'(o_if_stall), 32'd1);
        tick();
        chk("loaduse.bubble", 32'(o_id_valid), 32'd0);
        i_ex_valid = 1'b0;
        #1;
        chk("loaduse.release", 32'(o_if_stall), 32'd0);
        push(32'h8000_0004, 4'd8, 3'd0, 1'b0, 5'd3, 32'h22, 32'h11, 32'h0);
        tick();
        expect_out("add_after_load");

        // LUI: source fields coincide with the load rd but are unused
        i_ex_valid = 1'b1; i_ex_rd = 5'd27;
        present(32'h8000_0008, 32'hABCD_E0B7, 32'h1B1B, 32'h1C1C);
        chk("lui.no_hazard", 32'(o_if_stall), 32'd0);
        push(32'h8000_0008, 4'd0, 3'd6, 1'b0, 5'd1, 32'h1B1B, 32'h1C1C, 32'hABCD_E000);
        tick();
        expect_out("lui");
        i_ex_valid = 1'b0;

        // Writeback bypass onto rs1
        i_wb_valid = 1'b1; i_wb_rd = 5'd1; i_wb_value = 32'h1234;
        present(32'h8000_000C, 32'h0000_81B3, 32'h0, 32'h7777);
        push(32'h8000_000C, 4'd8, 3'd0, 1'b0, 5'd3, 32'h1234, 32'h0, 32'h0);
        tick();
        expect_out("bypass");
        // Writeback to x0 never bypasses
        i_wb_rd = 5'd0;
        present(32'h8000_0010, 32'h0000_01B3, 32'h5555, 32'h6666);
        push(32'h8000_0010, 4'd8, 3'd0, 1'b0, 5'd3, 32'h0, 32'h0, 32'h0);
        tick();
        expect_out("bypass_x0");
        // No bypass without writeback valid
        i_wb_valid = 1'b0; i_wb_rd = 5'd1;
        present(32'h8000_0014, 32'h0000_81B3, 32'h4321, 32'h6666);
        push(32'h8000_0014, 4'd8, 3'd0, 1'b0, 5'd3, 32'h4321, 32'h0, 32'h0);
        tick();
        expect_out("no_bypass");

        // Stall holds ID register for 3 cycles, then flush wins over stall
        i_stall = 1'b1;
        present(32'h8000_0018, 32'h0050_0093, 32'h1, 32'h2);
        for (int i = 0; i < 3; i++) begin
            chk("stall.if_stall", 32'(o_if_stall), 32'd1);
            tick();
            cmp_fields("stall.hold", last_exp);
        end
        i_flush = 1'b1;
        tick();
        chk("flush.valid", 32'(o_id_valid), 32'd0);
        i_flush = 1'b0; i_stall = 1'b0;

        // BEQ x0,x0,-4
        present(32'h8000_001C, 32'hFE00_0EE3, 32'h99, 32'h98);
        push(32'h8000_001C, 4'd4, 3'd0, 1'b1, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFC);
        tick();
        expect_out("beq");

        // JAL x1,+0x800 with a load to x1 in EX (rs2 field is not a source)
        i_ex_valid = 1'b1; i_ex_rd = 5'd1;
        present(32'h8000_0020, 32'h0010_00EF, 32'h31, 32'h32);
        chk("jal.no_hazard", 32'(o_if_stall), 32'd0);
        push(32'h8000_0020, 4'd2, 3'd0, 1'b0, 5'd1, 32'h0, 32'h32, 32'h0000_0800);
        tick();
        expect_out("jal");

        // SW x2,-8(x1) stalled on rs2 by a load to x2
        i_ex_rd = 5'd2;
        present(32'h8000_0024, 32'hFE20_AC23, 32'h41, 32'h42);
        chk("sw.hazard_rs2", 32'(o_if_stall), 32'd1);
        tick();
        chk("sw.bubble", 32'(o_id_valid), 32'd0);
        i_ex_valid = 1'b0;
        #1;
        push(32'h8000_0024, 4'd6, 3'd2, 1'b1, 5'd0, 32'h41, 32'h42, 32'hFFFF_FFF8);
        tick();
        expect_out("sw");

        // Illegal: all-zero word
        present(32'h8000_0028, 32'h0000_0000, 32'h51, 32'h52);
        push(32'h8000_0028, 4'd15, 3'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        expect_out("illegal_zero");

        // Illegal: SUB encoding with funct3=001; no hazard check on illegal
        i_ex_valid = 1'b1; i_ex_rd = 5'd1;
        present(32'h8000_002C, 32'h4020_91B3, 32'h61, 32'h62);
        chk("illegal_sub.no_hazard", 32'(o_if_stall), 32'd0);
        push(32'h8000_002C, 4'd15, 3'd1, 1'b1, 5'd0, 32'h61, 32'h62, 32'h0);
        tick();
        expect_out("illegal_sub");
        i_ex_valid = 1'b0;

        // Illegal: LOAD funct3=111
        present(32'h8000_0030, 32'h0000_F103, 32'h71, 32'h72);
        push(32'h8000_0030, 4'd15, 3'd7, 1'b0, 5'd0, 32'h71, 32'h0, 32'h0);
        tick();
        expect_out("illegal_load");

        // Core disable clears the register
        i_enable = 1'b0;
        present(32'h8000_0034, 32'h0050_0093, 32'h1, 32'h2);
        tick();
        expect_zero("disable");
        i_enable = 1'b1;

        present(32'h8000_0038, 32'h0050_0093, 32'h3, 32'h4);
        push(32'h8000_0038, 4'd7, 3'd0, 1'b0, 5'd1, 32'h0, 32'h4, 32'd5);
        tick();
        expect_out("reenable");

        // Asynchronous reset in the middle of a stall
        i_stall = 1'b1;
        tick();
        cmp_fields("stall2.hold", last_exp);
        #2;
        i_rst_n = 1'b0;
        #1;
        expect_zero("async_reset");
        tick();
        i_rst_n = 1'b1;
        i_stall = 1'b0;
        i_if_valid = 1'b0;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
